// File: rtl/spi_slave_sync_if.sv
// Bus bundle for spi_slave_sync: SPI pins plus the fabric-side TX/RX handshake.
interface spi_slave_sync_if #(
   parameter int WIDTH = 8
);
   logic             SCLK;
   logic             MOSI;
   logic             SS;
   logic             MISO;
   logic             miso_oe;
   logic [WIDTH-1:0] tx_data;
   logic             tx_load;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             tx_underrun;
   logic             frame_err;

   modport slave (
      input  SCLK, MOSI, SS, tx_data, tx_load,
      output MISO, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
   );

   modport master (
      output SCLK, MOSI, SS, tx_data, tx_load,
      input  MISO, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
   );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder, MSB first, oversampling SCLK/MOSI/SS on the system clock.
// One TX holding register feeds back-to-back words inside a single SS-low frame.
module spi_slave_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_slave_sync_if.slave bus
);
   localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CW    = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;
   state_t state, state_nx;

   logic [NSYNC-1:0] sclk_sync, mosi_sync, ss_sync;
   logic             sclk_s, mosi_s, ss_s, sclk_d, ss_d;
   logic             sclk_rise, sclk_fall, ss_rise, ss_fall;

   logic [WIDTH-1:0] hold, tx_shift, rx_shift, rx_data_q;
   logic             hold_full;
   logic [CW-1:0]    bit_cnt;
   logic             boundary, reload_pend, reload_full, rx_done;
   logic             rx_valid_q, underrun_q, frame_err_q;
   logic             in_shift, load_go, word_end, partial_end, tx_take, commit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[NSYNC-2:0], bus.SCLK};
         mosi_sync <= {mosi_sync[NSYNC-2:0], bus.MOSI};
         ss_sync   <= {ss_sync[NSYNC-2:0], bus.SS};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
      end
   end

   always_comb begin
      sclk_s    = sclk_sync[NSYNC-1];
      mosi_s    = mosi_sync[NSYNC-1];
      ss_s      = ss_sync[NSYNC-1];
      sclk_rise = sclk_s & ~sclk_d;
      sclk_fall = ~sclk_s & sclk_d;
      ss_fall   = ~ss_s & ss_d;
      ss_rise   = ss_s & ~ss_d;
   end

   always_comb begin
      in_shift    = (state == SHIFT);
      load_go     = (state == LOAD) & ~ss_rise;
      word_end    = in_shift & sclk_rise & (bit_cnt == LAST_BIT);
      partial_end = in_shift & ss_rise & ~word_end & (sclk_rise | (bit_cnt != '0));
      tx_take     = bus.tx_load & ~hold_full;
      commit      = in_shift & sclk_rise & reload_pend;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (ss_fall) state_nx = LOAD;
         LOAD:    state_nx = SHIFT;
         SHIFT:   state_nx = SHIFT;
         default: state_nx = IDLE;
      endcase
      if (ss_rise) state_nx = IDLE;
   end

   always_comb begin
      bus.MISO    = 1'b0;
      bus.miso_oe = 1'b0;
      if (state == SHIFT) begin
         bus.MISO    = tx_shift[WIDTH-1];
         bus.miso_oe = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (load_go) hold_full <= 1'b0;
         if (commit && reload_full) hold_full <= 1'b0;
         if (tx_take) begin
            hold      <= bus.tx_data;
            hold_full <= 1'b1;
         end
      end
   end

   // A word-boundary reload is presented on MISO at the SCLK fall but only committed
   // (holding freed or underrun flagged) at the next word's first rise, so the
   // trailing fall of a frame neither consumes the held word nor reports underrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data_q   <= '0;
         bit_cnt     <= '0;
         boundary    <= 1'b0;
         reload_pend <= 1'b0;
         reload_full <= 1'b0;
         rx_done     <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
         rx_done     <= 1'b0;
         rx_valid_q  <= rx_done;
         if (rx_done) rx_data_q <= rx_shift;

         if (load_go) begin
            tx_shift    <= hold_full ? hold : '0;
            underrun_q  <= ~hold_full;
            bit_cnt     <= '0;
            boundary    <= 1'b0;
            reload_pend <= 1'b0;
         end

         if (in_shift && sclk_rise) begin
            rx_shift <= (rx_shift << 1) | WIDTH'(mosi_s);
            bit_cnt  <= word_end ? '0 : bit_cnt + 1'b1;
            if (word_end) begin
               boundary <= 1'b1;
               rx_done  <= 1'b1;
            end
            if (reload_pend) begin
               reload_pend <= 1'b0;
               underrun_q  <= ~reload_full;
            end
         end

         if (in_shift && sclk_fall) begin
            if (boundary) begin
               tx_shift    <= hold_full ? hold : '0;
               reload_full <= hold_full;
               reload_pend <= 1'b1;
               boundary    <= 1'b0;
            end else begin
               tx_shift <= tx_shift << 1;
            end
         end

         if (ss_rise) begin
            boundary    <= 1'b0;
            reload_pend <= 1'b0;
         end
         if (partial_end) begin
            frame_err_q <= 1'b1;
            rx_shift    <= '0;
            bit_cnt     <= '0;
         end
      end
   end

   assign bus.tx_ready    = ~hold_full;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_underrun = underrun_q;
   assign bus.frame_err   = frame_err_q;
endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Clocked SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first, WIDTH-bit words.
- Runs on the system clock and oversamples SCLK, MOSI and SS through synchronizers.
- Gives the fabric a parallel TX load handshake and an RX valid strobe.
- Pairs with spi_master on the same SCLK/MOSI/MISO/SS bus; supports back-to-back words inside one SS-low frame.

Parameters:
- WIDTH, 8, bits per word.
- SYNC_STAGES, 2, flip-flop stages on SCLK/MOSI/SS (minimum 2).

Ports:
- clk  in  1  system clock; must run at ≥4× the SCLK frequency.
- rst_n  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock from master.
- MOSI  in  1  master-out data.
- SS  in  1  active-low slave select.
- MISO  out  1  slave-out data.
- miso_oe  out  1  high while SS is low (synced); drives the tri-state enable.
- tx_data  in  WIDTH  word to send next.
- tx_load  in  1  write strobe for tx_data; accepted only when tx_ready=1.
- tx_ready  out  1  TX holding register is empty.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse: a word started with the holding register empty.
- frame_err  out  1  one-cycle pulse: SS rose with a partial word in progress.

Behaviour:
- Reset (async assert, sync release) values:
  - MISO=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_err=0.
  - Shift registers and bit counter = 0; state = IDLE.
  - Synchronizers: SCLK chain = 0, SS chain = 1.
- Synchronized signals sclk_s, mosi_s, ss_s are taken after SYNC_STAGES flops.
  - sclk_rise = sclk_s & ~sclk_d; sclk_fall = ~sclk_s & sclk_d; ss_fall and ss_rise are formed the same way.
- TX holding register:
  - tx_load & tx_ready: capture tx_data, tx_ready <= 0 on the next cycle.
  - tx_load while tx_ready=0: ignored; the held word is unchanged.
- State machine: IDLE, LOAD, SHIFT.
  - IDLE: MISO=0, miso_oe=0. On ss_fall go to LOAD.
  - LOAD (one cycle):
    - Holding full: tx_shift <= holding, tx_ready <= 1.
    - Holding empty: tx_shift <= 0, tx_underrun pulses.
    - Then bit_cnt <= 0, miso_oe <= 1, go to SHIFT.
  - SHIFT:
    - MISO = tx_shift[WIDTH-1].
    - On sclk_rise: rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}, bit_cnt++.
    - When bit_cnt reaches WIDTH on a rise: rx_data <= the completed word and rx_valid pulses on the next clk. bit_cnt wraps to 0 and a word-boundary flag is set.
    - On sclk_fall with the flag clear: tx_shift <= tx_shift << 1.
    - On sclk_fall with the flag set: reload tx_shift from holding (or 0 with a tx_underrun pulse), clear the flag.
  - ss_rise in any state: go to IDLE, miso_oe <= 0, MISO <= 0.
    - bit_cnt ≠ 0: discard the partial rx_shift, no rx_valid, frame_err pulses.
    - bit_cnt == 0: clean end, no error.
- Latency:
  - MISO MSB is valid SYNC_STAGES+2 clk after the SS pin falls; the master must wait at least this long before the first SCLK rise.
  - rx_valid is asserted SYNC_STAGES+2 clk after the WIDTH-th SCLK pin rise.
- Simultaneous events:
  - tx_load in the same cycle as a LOAD or word-boundary reload: the reload takes the old holding value (empty → underrun). The new word is then captured and goes out in the next word.
  - ss_rise in the same cycle as the WIDTH-th sclk_rise: the word completes (rx_valid); no frame_err.
- SCLK edges while ss_s=1 are ignored.
- rx_data holds its value until the next complete word; there is no RX flow control, so the fabric must consume it within WIDTH SCLK periods.
- rst_n asserted mid-frame: all outputs return to reset values immediately. After release the block waits for a fresh ss_fall; it does not resume the frame.

Test Plan:
- Reset, tx_load 0x4F, master (clk 10 ns, SCLK ≥40 ns) sends 0x86 → MISO bit sequence 0,1,0,0,1,1,1,1; rx_data=0x86 with one rx_valid pulse; tx_ready high after LOAD.
- Two-word frame with SS held low: tx 0xA5 then 0x3C loaded during the first word; master sends 0x12, 0x34 → MISO 0xA5 then 0x3C; rx_valid twice, rx_data 0x12 then 0x34; no underrun.
- No tx_load before SS falls → tx_underrun pulses once; MISO all 0 for the word; rx still correct.
- SS raised after 5 SCLK rises → frame_err pulses; rx_valid stays 0; rx_data unchanged; miso_oe=0; the next full frame with 0xC3 receives correctly.
- tx_load while tx_ready=0 (0x11, then 0x22) → 0x11 is sent and 0x22 is dropped.
- rst_n pulsed low mid-word → all outputs at reset values within the same cycle; a subsequent frame of 0x5A is received cleanly.
